// File: rtl/rv_mem_loader.sv
// rtl/rv_mem_loader.sv - host-side IMEM loader, core run control and DMEM readback streamer
//
// Holds the core in reset and streams a program image into IMEM port B, starting at word 0.
// It then releases the core and waits for done_flag. After that it parks the core in reset
// again and streams a DMEM window back out. Readback data is buffered in a FIFO of depth
// LAT+1, so stalls on m_ready never drop data.
//
// Optional build macro: RV_LOADER_TIMEOUT_EN adds a RUN watchdog of TIMEOUT_CYC cycles.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   start                      job request pulse (honoured only when idle)
//   load_len/dump_base/dump_len job geometry, sampled on start
//   s_valid/s_ready/s_data     image word stream in
//   m_valid/m_ready/m_data     readback word stream out
//   core_rst_n, done_flag      core reset control and halt indication
//   imem_addr/imem_we/imem_din IMEM write port
//   dmem_addr/dmem_dout        DMEM read port (data LAT cycles after address)
//   busy, job_done, status     job state, completion pulse, 0 ok / 1 timeout
module rv_mem_loader #(
  parameter int ADDR_W      = 12,
  parameter int LAT         = 2,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [ADDR_W-1:0] dump_base,
  input  logic [ADDR_W:0]   dump_len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [31:0]       m_data,
  output logic              core_rst_n,
  input  logic              done_flag,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [3:0]        imem_we,
  output logic [31:0]       imem_din,
  output logic [ADDR_W-1:0] dmem_addr,
  input  logic [31:0]       dmem_dout,
  output logic              busy,
  output logic              job_done,
  output logic [1:0]        status
);

  localparam int DEPTH = LAT + 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);
  localparam int RUN_W = ($clog2(TIMEOUT_CYC + 1) > 2) ? $clog2(TIMEOUT_CYC + 1) : 2;
  localparam logic [CW:0] FIFO_DEPTH = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DUMP} state_t;

  state_t            state;
  logic [ADDR_W:0]   load_len_q;
  logic [ADDR_W:0]   dump_len_q;
  logic [ADDR_W:0]   load_cnt;
  logic [ADDR_W:0]   issue_cnt;
  logic [ADDR_W:0]   pop_cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [RUN_W-1:0]  run_cnt;
  logic [LAT-1:0]    vpipe;
  logic [31:0]       fifo_mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     fifo_cnt;
  logic [CW-1:0]     in_flight;
  logic [CW:0]       occ;
  logic              load_hs;
  logic              push;
  logic              pop;
  logic              issue;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign load_hs   = s_valid & s_ready;
  assign imem_we   = load_hs ? 4'hF : 4'h0;
  assign imem_addr = load_cnt[ADDR_W-1:0];
  assign imem_din  = s_data;

  // The read address is presented straight from the counter so that an issued read costs
  // exactly LAT cycles of FIFO credit; this is what allows one word per cycle.
  assign dmem_addr = rd_addr;
  assign push      = vpipe[LAT-1];
  assign m_valid   = (fifo_cnt != '0);
  assign pop       = m_valid & m_ready;
  assign m_data    = m_valid ? fifo_mem[rd_ptr] : 32'h0;

  // A slot being popped this cycle is free again at the edge, so it counts as credit now.
  assign occ   = {1'b0, in_flight} + {1'b0, fifo_cnt} - {{CW{1'b0}}, pop};
  assign issue = (state == S_DUMP) && (issue_cnt != dump_len_q) && (occ < FIFO_DEPTH);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= dmem_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      core_rst_n <= 1'b0;
      s_ready    <= 1'b0;
      busy       <= 1'b0;
      job_done   <= 1'b0;
      status     <= 2'd0;
      load_len_q <= '0;
      dump_len_q <= '0;
      load_cnt   <= '0;
      issue_cnt  <= '0;
      pop_cnt    <= '0;
      rd_addr    <= '0;
      run_cnt    <= '0;
      vpipe      <= '0;
      in_flight  <= '0;
      fifo_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      job_done  <= 1'b0;

      // Readback datapath: issue tracking, latency pipe and FIFO occupancy.
      vpipe     <= (vpipe << 1) | LAT'(issue);
      in_flight <= in_flight + CW'(issue) - CW'(push);
      fifo_cnt  <= fifo_cnt + CW'(push) - CW'(pop);
      if (issue) begin
        rd_addr   <= rd_addr + ADDR_W'(1);
        issue_cnt <= issue_cnt + 1'b1;
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) begin
        rd_ptr  <= ptr_inc(rd_ptr);
        pop_cnt <= pop_cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          core_rst_n <= 1'b0;
          if (start) begin
            load_len_q <= load_len;
            dump_len_q <= dump_len;
            rd_addr    <= dump_base;
            load_cnt   <= '0;
            issue_cnt  <= '0;
            pop_cnt    <= '0;
            status     <= 2'd0;
            busy       <= 1'b1;
            if (load_len == '0) begin
              state      <= S_RUN;
              core_rst_n <= 1'b1;
              run_cnt    <= '0;
            end else begin
              state   <= S_LOAD;
              s_ready <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (load_hs) begin
            load_cnt <= load_cnt + 1'b1;
            if (load_cnt == load_len_q - 1'b1) begin
              s_ready    <= 1'b0;
              state      <= S_RUN;
              core_rst_n <= 1'b1;
              run_cnt    <= '0;
            end
          end
        end

        S_RUN: begin
          // The first two RUN cycles ignore done_flag: it may still carry the previous halt.
`ifdef RV_LOADER_TIMEOUT_EN
          run_cnt <= run_cnt + RUN_W'(1);
          if ((run_cnt >= RUN_W'(2)) && done_flag) begin
            core_rst_n <= 1'b0;
            state      <= S_DUMP;
          end else if (run_cnt == RUN_W'(TIMEOUT_CYC - 1)) begin
            status     <= 2'd1;
            core_rst_n <= 1'b0;
            state      <= S_DUMP;
          end
`else
          if (run_cnt != RUN_W'(2)) run_cnt <= run_cnt + RUN_W'(1);
          if ((run_cnt == RUN_W'(2)) && done_flag) begin
            core_rst_n <= 1'b0;
            state      <= S_DUMP;
          end
`endif
        end

        S_DUMP: begin
          core_rst_n <= 1'b0;
          if ((dump_len_q == '0) || (pop && (pop_cnt == dump_len_q - 1'b1))) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            job_done <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mem_loader.sv
// tb/tb_rv_mem_loader.sv - self-checking bench for rv_mem_loader with IMEM/DMEM/core models
module tb_rv_mem_loader;

  localparam int ADDR_W = 12;
  localparam int LAT    = 2;
  localparam int MEMSZ  = 4096;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   load_len;
  logic [ADDR_W-1:0] dump_base;
  logic [ADDR_W:0]   dump_len;
  logic              s_valid;
  logic              s_ready;
  logic [31:0]       s_data;
  logic              m_valid;
  logic              m_ready;
  logic [31:0]       m_data;
  logic              core_rst_n;
  logic              done_flag;
  logic [ADDR_W-1:0] imem_addr;
  logic [3:0]        imem_we;
  logic [31:0]       imem_din;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_dout;
  logic              busy;
  logic              job_done;
  logic [1:0]        status;

  always #5 clk = ~clk;

  rv_mem_loader #(.ADDR_W(ADDR_W), .LAT(LAT), .TIMEOUT_CYC(50)) dut (
    .clk(clk), .rst(rst), .start(start), .load_len(load_len), .dump_base(dump_base),
    .dump_len(dump_len), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .core_rst_n(core_rst_n),
    .done_flag(done_flag), .imem_addr(imem_addr), .imem_we(imem_we), .imem_din(imem_din),
    .dmem_addr(dmem_addr), .dmem_dout(dmem_dout), .busy(busy), .job_done(job_done),
    .status(status)
  );

  // Memory and core models
  logic [31:0]       imem [MEMSZ];
  logic [31:0]       dmem [MEMSZ];
  logic [31:0]       img  [MEMSZ];
  logic [ADDR_W-1:0] ap   [LAT];
  int                done_delay = 1000000;
  int                run_cycles = 0;
  logic              done_q = 1'b1;

  always @(posedge clk) if (imem_we == 4'hF) imem[imem_addr] <= imem_din;

  always @(posedge clk) begin
    ap[0] <= dmem_addr;
    for (int k = 1; k < LAT; k++) ap[k] <= ap[k-1];
  end
  assign dmem_dout = dmem[ap[LAT-1]];

  // Core halts done_delay cycles after release; the flag holds while the core is in reset.
  always @(posedge clk) begin
    if (core_rst_n === 1'b1) begin
      run_cycles <= run_cycles + 1;
      done_q     <= (run_cycles + 1 >= done_delay);
    end else begin
      run_cycles <= 0;
    end
  end
  assign done_flag = done_q;

  // Per-cycle observation, sampled 2 time units after the falling edge
  int checks = 0, errors = 0;
  int core_hi, we_bad, wr_cnt, jd_cnt, mv_cycles, load_bad, fmax, gaps, last_pop, mon_cyc = 0;

  always begin
    @(negedge clk); #2;
    if (core_rst_n === 1'b1) core_hi++;
    if (imem_we !== ((s_valid && s_ready) ? 4'hF : 4'h0)) we_bad++;
    if (imem_we !== 4'h0) wr_cnt++;
    if (job_done === 1'b1) jd_cnt++;
    if (m_valid === 1'b1) mv_cycles++;
    if (core_rst_n === 1'b1 && s_ready === 1'b1) load_bad++;
    if (int'(dut.fifo_cnt) > fmax) fmax = int'(dut.fifo_cnt);
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      if (last_pop >= 0 && mon_cyc != last_pop + 1) gaps++;
      last_pop = mon_cyc;
    end
    mon_cyc++;
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    core_hi = 0; we_bad = 0; wr_cnt = 0; jd_cnt = 0; mv_cycles = 0;
    load_bad = 0; fmax = 0; gaps = 0; last_pop = -1;
  endtask

  task automatic run_job(input int ll, input int db, input int dl, input int dly,
                         input logic [3:0] pat, input bit rnd, input bit glitch,
                         input int exp_hi, input int exp_st);
    logic [31:0] got[$];
    int bad_i, bad_s, n;
    done_delay = dly;
    @(negedge clk);
    clear_mon();
    load_len  = (ADDR_W+1)'(ll);
    dump_base = ADDR_W'(db);
    dump_len  = (ADDR_W+1)'(dl);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fork
      begin
        int i = 0, c = 0;
        while (i < ll && c < 5000) begin
          s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
          s_data  = s_valid ? img[i] : $urandom;
          #2;
          if (s_valid && s_ready) i++;
          c++;
          @(negedge clk);
        end
        s_valid = 1'b0;
      end
      begin
        int k = 0, c = 0;
        while (got.size() < dl && c < 5000) begin
          m_ready = rnd ? 1'($urandom_range(0, 1)) : pat[k % 4];
          k++;
          #2;
          if (m_valid && m_ready) got.push_back(m_data);
          c++;
          @(negedge clk);
        end
        m_ready = 1'b0;
      end
      begin
        if (glitch) begin
          repeat (4) @(negedge clk);
          load_len = 13'd1; dump_len = 13'd1; dump_base = 12'd7; start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
    join
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      @(negedge clk); #2;
      n++;
    end
    repeat (2) @(negedge clk);
    #2;
    bad_i = 0;
    for (int k = 0; k < ll; k++) if (imem[k] !== img[k]) bad_i++;
    bad_s = 0;
    for (int k = 0; k < dl && k < got.size(); k++)
      if (got[k] !== dmem[(db + k) % MEMSZ]) bad_s++;
    check("idle_reached", longint'(busy), 0);
    check("imem_writes", wr_cnt, ll);
    check("imem_content_bad", bad_i, 0);
    check("stream_len", got.size(), dl);
    check("stream_words_bad", bad_s, 0);
    check("job_done_cycles", jd_cnt, 1);
    check("status", longint'(status), exp_st);
    check("core_run_cycles", core_hi, exp_hi);
    check("imem_we_rule", we_bad, 0);
    check("load_with_core_live", load_bad, 0);
    check("fifo_bound", longint'(fmax <= LAT + 1), 1);
    check("core_parked", longint'(core_rst_n), 0);
    if (!rnd && pat == 4'hF && dl > 0) check("pop_gaps", gaps, 0);
    if (dl == 0) check("m_valid_cycles", mv_cycles, 0);
  endtask

  typedef struct {
    int ll; int db; int dl; int dly;
    logic [3:0] pat; bit rnd; bit glitch;
    int exp_hi;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int ll, db, dl, dly, n;
    rst = 1'b1; start = 1'b0; load_len = '0; dump_base = '0; dump_len = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    for (int k = 0; k < MEMSZ; k++) begin
      dmem[k] = $urandom;
      img[k]  = $urandom;
    end

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check("rst_core_rst_n", longint'(core_rst_n), 0);
    check("rst_s_ready", longint'(s_ready), 0);
    check("rst_m_valid", longint'(m_valid), 0);
    check("rst_m_data", longint'(m_data), 0);
    check("rst_imem_we", longint'(imem_we), 0);
    check("rst_imem_addr", longint'(imem_addr), 0);
    check("rst_dmem_addr", longint'(dmem_addr), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_job_done", longint'(job_done), 0);
    check("rst_status", longint'(status), 0);
    rst = 1'b0;

    // ll, db, dl, dly, m_ready pattern, random, start glitch, core cycles released
    vecs[0] = '{3,    0,    2, 20, 4'hF,    1'b0, 1'b1, 21};
    vecs[1] = '{5,    100,  8, 4,  4'b1001, 1'b0, 1'b0, 5};
    vecs[2] = '{2,    4094, 4, 1,  4'hF,    1'b0, 1'b0, 3};
    vecs[3] = '{0,    0,    0, 7,  4'hF,    1'b0, 1'b0, 8};
    vecs[4] = '{16,   4000, 12, 2, 4'h0,    1'b1, 1'b0, 3};
    vecs[5] = '{1,    5,    1, 3,  4'hF,    1'b0, 1'b0, 4};

    img[0] = 32'h00500093; img[1] = 32'h00308113; img[2] = 32'h00202023;
    for (int v = 0; v < 6; v++) begin
      if (v > 0) for (int k = 0; k < vecs[v].ll; k++) img[k] = $urandom;
      run_job(vecs[v].ll, vecs[v].db, vecs[v].dl, vecs[v].dly, vecs[v].pat,
              vecs[v].rnd, vecs[v].glitch, vecs[v].exp_hi, 0);
    end

    // Reset during DUMP with the readback FIFO holding words
    done_delay = 5;
    @(negedge clk);
    clear_mon();
    load_len = '0; dump_base = 12'd50; dump_len = 13'd8; m_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (m_valid !== 1'b1 && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    check("dump_reached", longint'(m_valid), 1);
    repeat (3) @(negedge clk);
    #2;
    check("fifo_fill_stalled", fmax, LAT + 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #2;
    check("abort_core_rst_n", longint'(core_rst_n), 0);
    check("abort_m_valid", longint'(m_valid), 0);
    check("abort_busy", longint'(busy), 0);
    rst = 1'b0;

    // Randomised jobs against the reference rules
    for (int r = 0; r < 6; r++) begin
      ll  = $urandom_range(0, 20);
      db  = $urandom_range(0, MEMSZ - 1);
      dl  = $urandom_range(0, 20);
      dly = $urandom_range(1, 30);
      for (int k = 0; k < ll; k++) img[k] = $urandom;
      run_job(ll, db, dl, dly, 4'h0, 1'b1, 1'b0, ((dly > 2) ? dly : 2) + 1, 0);
    end

    // Core never halts
`ifdef RV_LOADER_TIMEOUT_EN
    run_job(4, 10, 3, 1 << 30, 4'hF, 1'b0, 1'b0, 50, 1);
`else
    done_delay = 1 << 30;
    @(negedge clk);
    load_len = '0; dump_len = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (1000) @(negedge clk);
    #2;
    check("hang_busy", longint'(busy), 1);
    check("hang_core_live", longint'(core_rst_n), 1);
    check("hang_status", longint'(status), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #2;
    check("hang_reset_busy", longint'(busy), 0);
    rst = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
